// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD digit source: FSM states, digit step
// arithmetic and load clamping.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam logic [3:0] BCD_MAX = 4'd9;

   typedef struct packed {
      logic [3:0] digit;
      logic       wrap;
   } step_t;

   function automatic step_t bcd_step(input logic [3:0] cur,
                                      input logic       up,
                                      input logic [3:0] max_d);
      step_t s;
      s.wrap  = 1'b0;
      s.digit = cur;
      if (up) begin
         if (cur == max_d) begin
            s.digit = '0;
            s.wrap  = 1'b1;
         end else begin
            s.digit = cur + 4'd1;
         end
      end else begin
         if (cur == '0) begin
            s.digit = max_d;
            s.wrap  = 1'b1;
         end else begin
            s.digit = cur - 4'd1;
         end
      end
      return s;
   endfunction

   function automatic logic [3:0] bcd_clamp(input logic [3:0] v,
                                            input logic [3:0] max_d);
      return (v > max_d) ? max_d : v;
   endfunction

endpackage

// File: rtl/bcd_digit_source_if.sv
// Control and valid/ready digit stream between the BCD source and its consumer.
interface bcd_digit_source_if;

   logic       en;
   logic       up;
   logic       load;
   logic [3:0] load_val;
   logic       out_ready;
   logic       out_valid;
   logic [3:0] digit;
   logic       wrap;
   logic       busy;

   modport master (
      output en, up, load, load_val, out_ready,
      input  out_valid, digit, wrap, busy
   );

   modport slave (
      input  en, up, load, load_val, out_ready,
      output out_valid, digit, wrap, busy
   );

endinterface

// File: rtl/tick_prescaler.sv
// Step-rate divider: pulses tick on the last of every DIV counted cycles while run=1.
module tick_prescaler #(
   parameter int unsigned DIV = 4,
   parameter int unsigned CW  = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic clr,
   output logic tick
);

   logic [CW-1:0] count;

   assign tick = run && (count == CW'(DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (run) begin
         count <= tick ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/bcd_digit_source.sv
// Paced BCD digit source (0..MAX_DIGIT, up/down, load, hold) offering each new
// digit on a valid/ready handshake; digit[3] drives converter input a.
module bcd_digit_source
   import bcd_pkg::*;
#(
   parameter int unsigned DIV       = 4,
   parameter int unsigned MAX_DIGIT = 9,
   parameter int unsigned CW        = 3
) (
   input logic                 clk,
   input logic                 rst_n,
   bcd_digit_source_if.slave   bus
);

   localparam logic [3:0] MAX_D = 4'(MAX_DIGIT);

   state_t     state_q, state_d;
   logic [3:0] digit_q, digit_d;
   logic       valid_q, valid_d;
   logic       wrap_q,  wrap_d;
   logic       hs, stall, run, clr, tick;
   step_t      nxt;

   assign hs    = valid_q && bus.out_ready;
   assign stall = valid_q && !bus.out_ready;
   // Prescaler also pauses while an offered digit waits in RUN, so it cannot be overwritten.
   assign run   = (state_q == RUN) && bus.en && !stall;
   assign clr   = bus.load || ((state_q == RUN) && !bus.en);
   assign nxt   = bcd_step(digit_q, bus.up, MAX_D);

   tick_prescaler #(
      .DIV (DIV),
      .CW  (CW)
   ) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .run   (run),
      .clr   (clr),
      .tick  (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         digit_q <= '0;
         valid_q <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         digit_q <= digit_d;
         valid_q <= valid_d;
         wrap_q  <= wrap_d;
      end
   end

   always_comb begin
      state_d = state_q;
      digit_d = digit_q;
      valid_d = valid_q && !hs;
      wrap_d  = 1'b0;
      if (bus.load) begin
         digit_d = bcd_clamp(bus.load_val, MAX_D);
         valid_d = 1'b1;
         if (!bus.out_ready) state_d = HOLD;
         else                state_d = bus.en ? RUN : IDLE;
      end else begin
         unique case (state_q)
            IDLE: if (bus.en) state_d = RUN;
            RUN: begin
               if (!bus.en) begin
                  state_d = IDLE;
               end else if (stall) begin
                  state_d = HOLD;
               end else if (tick) begin
                  digit_d = nxt.digit;
                  wrap_d  = nxt.wrap;
                  valid_d = 1'b1;
                  if (!bus.out_ready) state_d = HOLD;
               end
            end
            HOLD: if (hs) state_d = RUN;
            default: state_d = IDLE;
         endcase
      end
   end

   assign bus.out_valid = valid_q;
   assign bus.digit     = digit_q;
   assign bus.wrap      = wrap_q;
   assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_bcd_digit_source.sv
// Scoreboard bench for bcd_digit_source: directed stimulus pushes expected
// digits; a negedge monitor pops and compares on every handshake.
module tb_bcd_digit_source;

   logic clk;
   logic rst_n;

   bcd_digit_source_if bus ();

   bcd_digit_source #(
      .DIV       (4),
      .MAX_DIGIT (9),
      .CW        (3)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [3:0] d;
      logic       w;
   } exp_t;

   exp_t q[$];
   int   passed = 0;
   int   total  = 0;
   bit   fresh  = 1'b1;
   logic offer_wrap = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp_v);
      total++;
      if (act == exp_v) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [3:0] d, input logic w);
      exp_t e;
      e.d = d;
      e.w = w;
      q.push_back(e);
   endtask

   // wrap is a one-cycle pulse, so it is captured when an offer first appears
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!bus.out_valid) begin
         fresh = 1'b1;
      end else begin
         if (fresh) begin
            offer_wrap = bus.wrap;
            fresh      = 1'b0;
         end
         if (bus.out_ready) begin
            if (q.size() == 0) begin
               total++;
               $display("FAIL sb_unexpected: got digit %0d, expected no offer", bus.digit);
            end else begin
               e = q.pop_front();
               chk("sb_digit", int'(bus.digit), int'(e.d));
               chk("sb_wrap", int'(offer_wrap), int'(e.w));
            end
            fresh = 1'b1;
         end
      end
   end

   initial begin : stim
      bit hold_ok;
      rst_n         = 1'b0;
      bus.en        = 1'b1;
      bus.up        = 1'b1;
      bus.load      = 1'b0;
      bus.load_val  = 4'd0;
      bus.out_ready = 1'b1;

      cyc(3);
      chk("rst_digit", int'(bus.digit), 0);
      chk("rst_valid", int'(bus.out_valid), 0);
      chk("rst_wrap", int'(bus.wrap), 0);
      chk("rst_busy", int'(bus.busy), 0);

      for (int i = 1; i <= 9; i++) push(4'(i), 1'b0);
      push(4'd0, 1'b1);
      rst_n = 1'b1;

      // IDLE->RUN takes one edge, then DIV counted cycles until the first step
      cyc(4);
      chk("first_tick_early", int'(bus.out_valid), 0);
      cyc(1);
      chk("first_valid", int'(bus.out_valid), 1);
      chk("first_digit", int'(bus.digit), 1);
      chk("busy_run", int'(bus.busy), 1);

      cyc(36);
      chk("up_wrap_digit", int'(bus.digit), 0);
      chk("up_wrap_pulse", int'(bus.wrap), 1);

      push(4'd2, 1'b0);
      push(4'd1, 1'b0);
      push(4'd0, 1'b0);
      push(4'd9, 1'b1);
      bus.up       = 1'b0;
      bus.load     = 1'b1;
      bus.load_val = 4'd2;
      cyc(1);
      bus.load = 1'b0;
      chk("load2_digit", int'(bus.digit), 2);
      cyc(12);
      chk("down_wrap_digit", int'(bus.digit), 9);
      chk("down_wrap_pulse", int'(bus.wrap), 1);

      push(4'd9, 1'b0);
      bus.load     = 1'b1;
      bus.load_val = 4'hC;
      cyc(1);
      chk("clamp_digit", int'(bus.digit), 9);
      chk("clamp_wrap", int'(bus.wrap), 0);

      push(4'd4, 1'b0);
      push(4'd5, 1'b0);
      push(4'd6, 1'b0);
      bus.load_val = 4'd4;
      bus.up       = 1'b1;
      cyc(1);
      bus.load = 1'b0;
      cyc(4);
      chk("bp_digit5", int'(bus.digit), 5);
      bus.out_ready = 1'b0;
      hold_ok = 1'b1;
      for (int i = 0; i < 20; i++) begin
         cyc(1);
         if (bus.digit != 4'd5 || bus.out_valid != 1'b1) hold_ok = 1'b0;
      end
      chk("bp_hold_stable", int'(hold_ok), 1);
      chk("bp_busy", int'(bus.busy), 1);
      bus.out_ready = 1'b1;
      cyc(4);
      chk("bp_resume_early", int'(bus.out_valid), 0);
      cyc(1);
      chk("bp_resume_valid", int'(bus.out_valid), 1);
      chk("bp_resume_digit", int'(bus.digit), 6);

      cyc(3);
      bus.out_ready = 1'b0;
      cyc(1);
      chk("hold7_digit", int'(bus.digit), 7);
      chk("hold7_valid", int'(bus.out_valid), 1);
      push(4'd3, 1'b0);
      push(4'd4, 1'b0);
      bus.load     = 1'b1;
      bus.load_val = 4'd3;
      cyc(1);
      bus.load = 1'b0;
      chk("hold_load_digit", int'(bus.digit), 3);
      chk("hold_load_valid", int'(bus.out_valid), 1);
      bus.out_ready = 1'b1;
      cyc(5);
      chk("after_hold_digit", int'(bus.digit), 4);

      cyc(1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_digit", int'(bus.digit), 0);
      chk("async_valid", int'(bus.out_valid), 0);
      chk("async_wrap", int'(bus.wrap), 0);
      chk("async_busy", int'(bus.busy), 0);

      cyc(2);
      bus.en = 1'b0;
      rst_n  = 1'b1;
      cyc(3);
      chk("idle_busy", int'(bus.busy), 0);
      chk("sb_drained", q.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
